// File: rtl/cxu_l0_reduce_requester.sv
// CXU-L0 requester: streams a frame of words into a combinational CXU-L0 responder,
// one request per clock, and reports the sum of OK responses, word count and error flag.
module cxu_l0_reduce_requester #(
   parameter int unsigned CXU_ID_W  = 1,
   parameter int unsigned FUNC_ID_W = 10,
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned STATUS_W  = 4,
   parameter int unsigned ACC_W     = 48,
   parameter int unsigned COUNT_W   = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [CXU_ID_W-1:0]  cfg_cxu,
   input  logic [FUNC_ID_W-1:0] cfg_func,
   input  logic [DATA_W-1:0]    cfg_data1,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [DATA_W-1:0]    in_data,
   input  logic                 in_last,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [ACC_W-1:0]     out_sum,
   output logic [COUNT_W-1:0]   out_count,
   output logic                 out_err,
   output logic                 req_valid,
   output logic [CXU_ID_W-1:0]  req_cxu,
   output logic [FUNC_ID_W-1:0] req_func,
   output logic [DATA_W-1:0]    req_data0,
   output logic [DATA_W-1:0]    req_data1,
   input  logic [STATUS_W-1:0]  resp_status,
   input  logic [DATA_W-1:0]    resp_data
);

   if (!(DATA_W == 32 || DATA_W == 64)) begin : g_bad_data_w
      $error("cxu_l0_reduce_requester: DATA_W must be 32 or 64");
   end
   if (ACC_W < DATA_W) begin : g_bad_acc_w
      $error("cxu_l0_reduce_requester: ACC_W must be >= DATA_W");
   end

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t               state_q, state_d;
   logic                 hold_valid_q, hold_valid_d;
   logic                 hold_last_q, hold_last_d;
   logic [DATA_W-1:0]    hold_data_q, hold_data_d;
   logic [CXU_ID_W-1:0]  cfg_cxu_q, cfg_cxu_d;
   logic [FUNC_ID_W-1:0] cfg_func_q, cfg_func_d;
   logic [DATA_W-1:0]    cfg_data1_q, cfg_data1_d;
   logic [ACC_W-1:0]     acc_q, acc_d;
   logic [COUNT_W-1:0]   count_q, count_d;
   logic                 err_q, err_d;
   logic                 out_valid_q, out_valid_d;
   logic                 accept;

   // A held last word blocks further input until the frame result is consumed.
   assign in_ready = !rst && (state_q != DONE) && !(hold_valid_q && hold_last_q);
   assign accept   = in_valid && in_ready;

   always_comb begin
      state_d     = state_q;
      cfg_cxu_d   = cfg_cxu_q;
      cfg_func_d  = cfg_func_q;
      cfg_data1_d = cfg_data1_q;
      acc_d       = acc_q;
      count_d     = count_q;
      err_d       = err_q;
      out_valid_d = out_valid_q;
      // Responder has no backpressure, so a held word always issues and drains.
      hold_valid_d = accept;
      hold_last_d  = accept ? in_last : hold_last_q;
      hold_data_d  = accept ? in_data : hold_data_q;

      case (state_q)
         IDLE: begin
            if (accept) begin
               cfg_cxu_d   = cfg_cxu;
               cfg_func_d  = cfg_func;
               cfg_data1_d = cfg_data1;
               acc_d       = '0;
               count_d     = '0;
               err_d       = 1'b0;
               state_d     = RUN;
            end
         end
         RUN: begin
            if (hold_valid_q) begin
               count_d = count_q + COUNT_W'(1);
               if (resp_status == '0) begin
                  acc_d = acc_q + ACC_W'(resp_data);
               end else begin
                  err_d = 1'b1;
               end
               if (hold_last_q) begin
                  state_d     = DONE;
                  out_valid_d = 1'b1;
               end
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d     = IDLE;
               out_valid_d = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         hold_valid_q <= 1'b0;
         hold_last_q  <= 1'b0;
         hold_data_q  <= '0;
         cfg_cxu_q    <= '0;
         cfg_func_q   <= '0;
         cfg_data1_q  <= '0;
         acc_q        <= '0;
         count_q      <= '0;
         err_q        <= 1'b0;
         out_valid_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         hold_valid_q <= hold_valid_d;
         hold_last_q  <= hold_last_d;
         hold_data_q  <= hold_data_d;
         cfg_cxu_q    <= cfg_cxu_d;
         cfg_func_q   <= cfg_func_d;
         cfg_data1_q  <= cfg_data1_d;
         acc_q        <= acc_d;
         count_q      <= count_d;
         err_q        <= err_d;
         out_valid_q  <= out_valid_d;
      end
   end

   assign req_valid = hold_valid_q;
   assign req_data0 = hold_data_q;
   assign req_cxu   = cfg_cxu_q;
   assign req_func  = cfg_func_q;
   assign req_data1 = cfg_data1_q;
   assign out_valid = out_valid_q;
   assign out_sum   = acc_q;
   assign out_count = count_q;
   assign out_err   = err_q;

endmodule

// File: tb/tb_cxu_l0_reduce_requester.sv
// Randomized self-checking bench for cxu_l0_reduce_requester with an in-bench
// CXU-L0 responder and a frame-level reference model.
module tb_cxu_l0_reduce_requester;

   logic        clk = 1'b0;
   logic        rst;
   logic [0:0]  cfg_cxu;
   logic [9:0]  cfg_func;
   logic [31:0] cfg_data1;
   logic        in_valid, in_ready, in_last;
   logic [31:0] in_data;
   logic        out_valid, out_ready, out_err;
   logic [47:0] out_sum;
   logic [15:0] out_count;
   logic        req_valid;
   logic [0:0]  req_cxu;
   logic [9:0]  req_func;
   logic [31:0] req_data0, req_data1;
   logic [3:0]  resp_status;
   logic [31:0] resp_data;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;
   int tot_req = 0;
   int mode = 0;        // 0 popcount, 1 constant 5, 2 echo
   int err_idx = -1;    // global request index that gets a non-OK status
   logic [3:0] err_stat = 4'd1;

   typedef struct {
      int          due;
      logic [31:0] data;
      logic [0:0]  cxu;
      logic [9:0]  func;
      logic [31:0] d1;
   } req_t;
   req_t exp_q[$];

   cxu_l0_reduce_requester #(
      .CXU_ID_W(1), .FUNC_ID_W(10), .DATA_W(32), .STATUS_W(4), .ACC_W(48), .COUNT_W(16)
   ) dut (
      .clk(clk), .rst(rst),
      .cfg_cxu(cfg_cxu), .cfg_func(cfg_func), .cfg_data1(cfg_data1),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
      .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
      .out_count(out_count), .out_err(out_err),
      .req_valid(req_valid), .req_cxu(req_cxu), .req_func(req_func),
      .req_data0(req_data0), .req_data1(req_data1),
      .resp_status(resp_status), .resp_data(resp_data)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] respond(input logic [31:0] w, input int m);
      case (m)
         0:       return 32'($countones(w));
         1:       return 32'd5;
         default: return w;
      endcase
   endfunction

   always_comb begin
      resp_data   = respond(req_data0, mode);
      resp_status = (err_idx >= 0 && tot_req == err_idx) ? err_stat : 4'd0;
   end

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (req_valid) tot_req <= tot_req + 1;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Request scoreboard: each accepted word must appear as a request exactly one clock later.
   always @(negedge clk) begin
      if (!rst) begin
         if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            check("req_valid", 64'(req_valid), 64'd1);
            check("req_data0", 64'(req_data0), 64'(exp_q[0].data));
            check("req_cxu",   64'(req_cxu),   64'(exp_q[0].cxu));
            check("req_func",  64'(req_func),  64'(exp_q[0].func));
            check("req_data1", 64'(req_data1), 64'(exp_q[0].d1));
            void'(exp_q.pop_front());
         end else begin
            check("req_idle", 64'(req_valid), 64'd0);
         end
      end
   end

   function automatic logic [47:0] model_sum(input logic [31:0] w[$], input int m, input int ep);
      logic [47:0] s = '0;
      foreach (w[i]) if (i != ep) s += 48'(respond(w[i], m));
      return s;
   endfunction

   task automatic send_frame(input logic [31:0] w[$], input int gap_pct);
      int i = 0;
      int guard = 0;
      logic [0:0]  fc = '0;
      logic [9:0]  ff = '0;
      logic [31:0] fd = '0;
      while (i < w.size() && guard < 2000) begin
         @(negedge clk);
         guard++;
         cfg_cxu   = 1'($urandom);
         cfg_func  = 10'($urandom);
         cfg_data1 = $urandom;
         if (int'($urandom_range(99)) < gap_pct) begin
            in_valid = 1'b0;
            in_data  = $urandom;
            in_last  = 1'($urandom);
         end else begin
            in_valid = 1'b1;
            in_data  = w[i];
            in_last  = (i == w.size() - 1);
         end
         if (in_valid && in_ready) begin
            if (i == 0) begin
               fc = cfg_cxu; ff = cfg_func; fd = cfg_data1;
            end
            exp_q.push_back('{due: cyc + 1, data: w[i], cxu: fc, func: ff, d1: fd});
            i++;
         end
      end
      check("send_timeout", 64'(i), 64'(w.size()));
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic wait_result(input logic [47:0] es, input int ec, input bit ee,
                              input int stall, input string tag);
      int g = 0;
      while (!out_valid && g < 300) begin
         @(negedge clk);
         g++;
      end
      check({tag, "_out_valid"}, 64'(out_valid), 64'd1);
      if (!out_valid) return;
      check({tag, "_sum"},   64'(out_sum),   64'(es));
      check({tag, "_count"}, 64'(out_count), 64'(16'(ec)));
      check({tag, "_err"},   64'(out_err),   64'(ee));
      repeat (stall) begin
         @(negedge clk);
         in_valid = 1'b1;
         in_data  = $urandom;
         in_last  = 1'($urandom);
         check({tag, "_hold_valid"}, 64'(out_valid), 64'd1);
         check({tag, "_hold_sum"},   64'(out_sum),   64'(es));
         check({tag, "_hold_count"}, 64'(out_count), 64'(16'(ec)));
         check({tag, "_hold_err"},   64'(out_err),   64'(ee));
         check({tag, "_hold_rdy"},   64'(in_ready),  64'd0);
      end
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check({tag, "_release_valid"}, 64'(out_valid), 64'd0);
      check({tag, "_release_rdy"},   64'(in_ready),  64'd1);
   endtask

   task automatic run_frame(input logic [31:0] w[$], input int m, input int ep,
                            input int gap, input int stall, input string tag);
      mode     = m;
      err_stat = 4'($urandom_range(15, 1));
      err_idx  = (ep < 0) ? -1 : tot_req + ep;
      send_frame(w, gap);
      wait_result(model_sum(w, m, ep), w.size(), ep >= 0, stall, tag);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] w[$];
      rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
      cfg_cxu = 1'b1; cfg_func = 10'h155; cfg_data1 = 32'hDEADBEEF;

      repeat (3) @(negedge clk);
      check("rst_in_ready",  64'(in_ready),  64'd0);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out_sum",   64'(out_sum),   64'd0);
      check("rst_out_count", 64'(out_count), 64'd0);
      check("rst_out_err",   64'(out_err),   64'd0);
      check("rst_req_valid", 64'(req_valid), 64'd0);
      check("rst_req_cxu",   64'(req_cxu),   64'd0);
      check("rst_req_func",  64'(req_func),  64'd0);
      check("rst_req_data0", 64'(req_data0), 64'd0);
      check("rst_req_data1", 64'(req_data1), 64'd0);
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_in_ready", 64'(in_ready), 64'd1);

      w = {32'hFFFFFFFF, 32'h0000000F, 32'h80000001};
      run_frame(w, 0, -1, 0, 0, "popcnt3");

      w = {32'h00000000};
      mode = 0; err_idx = -1;
      send_frame(w, 0);
      check("single_lat1", 64'(out_valid), 64'd0);
      @(negedge clk);
      check("single_lat2", 64'(out_valid), 64'd1);
      wait_result(48'd0, 1, 1'b0, 0, "single");

      w = {$urandom, $urandom, $urandom, $urandom};
      run_frame(w, 1, 1, 0, 0, "stub_err");

      w = {$urandom, $urandom, $urandom};
      run_frame(w, 2, -1, 20, 10, "stall10");

      w = {};
      for (int i = 0; i < 64; i++) w.push_back(32'hFFFFFFFF);
      run_frame(w, 0, -1, 40, 0, "ones64_a");
      run_frame(w, 0, -1, 40, 0, "ones64_b");

      // Abort a frame after three issued words.
      mode = 0; err_idx = -1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         in_valid = 1'b1; in_data = 32'(k + 1); in_last = 1'b0;
         check("abort_rdy", 64'(in_ready), 64'd1);
         exp_q.push_back('{due: cyc + 1, data: 32'(k + 1), cxu: cfg_cxu,
                           func: cfg_func, d1: cfg_data1});
      end
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      exp_q.delete();
      @(negedge clk);
      check("abort_in_ready",  64'(in_ready),  64'd0);
      check("abort_out_valid", 64'(out_valid), 64'd0);
      check("abort_out_sum",   64'(out_sum),   64'd0);
      check("abort_out_count", 64'(out_count), 64'd0);
      check("abort_out_err",   64'(out_err),   64'd0);
      check("abort_req_valid", 64'(req_valid), 64'd0);
      check("abort_req_func",  64'(req_func),  64'd0);
      check("abort_req_data0", 64'(req_data0), 64'd0);
      rst = 1'b0;
      @(negedge clk);
      check("abort_post_rdy", 64'(in_ready), 64'd1);
      w = {32'h00000007};
      run_frame(w, 0, -1, 0, 0, "after_abort");

      for (int f = 0; f < 30; f++) begin
         int len;
         int ep;
         len = int'($urandom_range(8, 1));
         w = {};
         for (int i = 0; i < len; i++) w.push_back($urandom);
         ep = ($urandom_range(2) == 0) ? int'($urandom_range(len - 1)) : -1;
         run_frame(w, int'($urandom_range(2)), ep, int'($urandom_range(60)),
                   int'($urandom_range(3)), "rand");
      end

      repeat (3) @(negedge clk);
      check("final_queue_empty", 64'(exp_q.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
